display_scheduler: RTL

- Owns the shared 4-digit 7-segment display and decides which source drives it.
- Takes the 1 kHz digit tick and 2-bit digit index from the display refresh divider.
- Arbitrates between the always-present score source and a priority message source that holds the display for a fixed number of ticks.
- Inserts a blanking interval on every digit switch to suppress ghosting, and latches source data once per frame so a frame never shows a mix of old and new data.

---
 rtl/display_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// Drives the shared 4-digit 7-segment display from either the score source or a
// held priority message. It blanks between digits and snapshots data once per frame.
module display_scheduler #(
    parameter int unsigned HOLD_TICKS = 2000,
    parameter int unsigned BLANK_CYC  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ref_sign,
    input  logic [1:0]  refresh,
    input  logic [15:0] score_data,
    input  logic        msg_req,
    input  logic [15:0] msg_data,
    output logic        msg_ack,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        owner
);

    typedef enum logic {SCORE = 1'b0, MSG = 1'b1} state_t;

    localparam logic [15:0] HOLD_V  = 16'(HOLD_TICKS);
    localparam logic [15:0] BLANK_V = 16'(BLANK_CYC);

    state_t      state_q;
    logic [15:0] hold_q;
    logic        msg_ack_q;
    logic [15:0] msg_q;
    logic [15:0] snap_q, snap_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] blank_q, blank_d;
    logic        run_q, run_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        accept;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return {1'b1, s};
    endfunction

    function automatic logic [3:0] anode(input logic [1:0] k);
        return ~(4'b0001 << k);
    endfunction

    // The cycle after an ack ignores msg_req so the source has time to drop it.
    assign accept = msg_req && !msg_ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCORE;
            hold_q    <= 16'd0;
            msg_ack_q <= 1'b0;
        end else begin
            msg_ack_q <= 1'b0;
            case (state_q)
                SCORE: begin
                    if (accept) begin
                        state_q   <= MSG;
                        hold_q    <= HOLD_V;
                        msg_ack_q <= 1'b1;
                    end
                end
                MSG: begin
                    if (accept) begin
                        hold_q    <= HOLD_V;
                        msg_ack_q <= 1'b1;
                    end else if (ref_sign && hold_q != 16'd0) begin
                        hold_q <= hold_q - 16'd1;
                        if (hold_q == 16'd1) state_q <= SCORE;
                    end
                end
                default: state_q <= SCORE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) msg_q <= msg_data;
    end

    always_comb begin
        snap_d  = snap_q;
        idx_d   = idx_q;
        blank_d = blank_q;
        run_d   = run_q;
        an_d    = an_q;
        seg_d   = seg_q;
        // Owner is sampled as it stands this cycle, so a hand-over waits for the next frame.
        if (ref_sign && refresh == 2'd0)
            snap_d = (state_q == MSG) ? msg_q : score_data;
        if (ref_sign) begin
            run_d   = 1'b1;
            idx_d   = refresh;
            blank_d = 16'd0;
            seg_d   = seg_decode(snap_d[{refresh, 2'b00} +: 4]);
            an_d    = (BLANK_V == 16'd0) ? anode(refresh) : 4'hF;
        end else if (run_q && blank_q != BLANK_V) begin
            blank_d = blank_q + 16'd1;
            if (blank_d == BLANK_V) an_d = anode(idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q  <= 16'h0;
            idx_q   <= 2'd0;
            blank_q <= 16'd0;
            run_q   <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
        end else begin
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
            run_q   <= run_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign msg_ack = msg_ack_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign owner   = (state_q == MSG);

endmodule
